// File: rtl/regfile_pkg.sv
// Shared definitions for the two-port register-file arbiter.
package regfile_pkg;

  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefSelW    = 3;
  localparam int unsigned DefLockTmo = 15;

  // Register index constants.
  localparam logic [DefSelW-1:0] R0 = 3'd0;
  localparam logic [DefSelW-1:0] R1 = 3'd1;
  localparam logic [DefSelW-1:0] R2 = 3'd2;
  localparam logic [DefSelW-1:0] R3 = 3'd3;
  localparam logic [DefSelW-1:0] R4 = 3'd4;
  localparam logic [DefSelW-1:0] SP = 3'd5;
  localparam logic [DefSelW-1:0] MD = 3'd6;
  localparam logic [DefSelW-1:0] MA = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } state_e;

  // Ownership state for a requester index.
  function automatic state_e own_state(logic idx);
    return idx ? StOwn1 : StOwn0;
  endfunction

endpackage

// File: rtl/regfile_grant_fsm.sv
// Round-robin grant and lock/timeout FSM for two requesters.
module regfile_grant_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned LOCK_TMO = DefLockTmo
) (
  input  logic clk,
  input  logic clear,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_lock0,
  input  logic i_lock1,
  output logic o_ready0,
  output logic o_ready1,
  output logic o_lock_timeout
);

  localparam int unsigned CntW = (LOCK_TMO > 1) ? $clog2(LOCK_TMO + 1) : 1;
  localparam logic [CntW-1:0] TmoLast = CntW'(LOCK_TMO - 1);

  state_e          r_state;
  logic            r_last_gnt;
  logic [CntW-1:0] r_cnt;
  logic            r_tmo;
  logic            r_tmo_owner;

  logic w_gnt0;
  logic w_gnt1;
  logic w_xfer;
  logic w_idx;
  logic w_lock;

  // Zero-cycle grant from current state and valids; nothing granted during clear.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!clear) begin
      case (r_state)
        StIdle: begin
          if (i_valid0 && i_valid1) begin
            // Right after a forced release the previous owner yields.
            if (r_tmo) begin
              w_gnt0 = r_tmo_owner;
              w_gnt1 = ~r_tmo_owner;
            end else begin
              w_gnt0 = r_last_gnt;
              w_gnt1 = ~r_last_gnt;
            end
          end else begin
            w_gnt0 = i_valid0;
            w_gnt1 = i_valid1;
          end
        end
        StOwn0:  w_gnt0 = i_valid0;
        StOwn1:  w_gnt1 = i_valid1;
        default: ;
      endcase
    end
  end

  assign w_xfer = w_gnt0 | w_gnt1;
  assign w_idx  = w_gnt1;
  assign w_lock = w_gnt1 ? i_lock1 : i_lock0;

  // State, round-robin pointer, idle-owner counter and registered timeout pulse.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state     <= StIdle;
      r_last_gnt  <= 1'b1;
      r_cnt       <= '0;
      r_tmo       <= 1'b0;
      r_tmo_owner <= 1'b0;
    end else begin
      r_tmo <= 1'b0;
      if (w_xfer) begin
        r_last_gnt <= w_idx;
        r_cnt      <= '0;
        r_state    <= w_lock ? own_state(w_idx) : StIdle;
      end else if (r_state != StIdle) begin
        if (r_cnt == TmoLast) begin
          r_state     <= StIdle;
          r_cnt       <= '0;
          r_tmo       <= 1'b1;
          r_tmo_owner <= (r_state == StOwn1);
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign o_ready0       = w_gnt0;
  assign o_ready1       = w_gnt1;
  assign o_lock_timeout = r_tmo;

endmodule

// File: rtl/regfile_arbiter.sv
// Two-requester register-file arbiter: grant FSM plus read/write datapath.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned SEL_W    = DefSelW,
  parameter int unsigned LOCK_TMO = DefLockTmo
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req0_lock,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic              req1_lock,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic [DATA_W-1:0] rf_dataIn,
  output logic [SEL_W-1:0]  rf_writeSelect,
  output logic              rf_writeEnable,
  output logic [SEL_W-1:0]  rf_readSelect,
  input  logic [DATA_W-1:0] rf_dataOut,
  output logic              lock_timeout
);

  logic              w_xfer0;
  logic              w_xfer1;
  logic              w_rd0;
  logic              w_rd1;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [SEL_W-1:0]  w_sel;
  logic [DATA_W-1:0] w_wdata;

  logic              r_rvalid0;
  logic              r_rvalid1;
  logic [DATA_W-1:0] r_rdata0;
  logic [DATA_W-1:0] r_rdata1;
  logic [SEL_W-1:0]  r_read_sel;

  regfile_grant_fsm #(
    .LOCK_TMO(LOCK_TMO)
  ) u_grant_fsm (
    .clk           (clk),
    .clear         (clear),
    .i_valid0      (req0_valid),
    .i_valid1      (req1_valid),
    .i_lock0       (req0_lock),
    .i_lock1       (req1_lock),
    .o_ready0      (req0_ready),
    .o_ready1      (req1_ready),
    .o_lock_timeout(lock_timeout)
  );

  assign w_xfer0  = req0_valid & req0_ready;
  assign w_xfer1  = req1_valid & req1_ready;
  assign w_rd0    = w_xfer0 & ~req0_write;
  assign w_rd1    = w_xfer1 & ~req1_write;
  assign w_wr_acc = (w_xfer0 & req0_write) | (w_xfer1 & req1_write);
  assign w_rd_acc = w_rd0 | w_rd1;

  // Grants are exclusive, so the granted requester steers the shared mux.
  assign w_sel   = w_xfer1 ? req1_sel : req0_sel;
  assign w_wdata = w_xfer1 ? req1_wdata : req0_wdata;

  assign rf_writeEnable = w_wr_acc & ~clear;
  assign rf_writeSelect = w_sel;
  assign rf_dataIn      = w_wdata;
  // Read select follows an accepted read now, otherwise holds its last value.
  assign rf_readSelect  = w_rd_acc ? w_sel : r_read_sel;

  // Capture read data one cycle after acceptance; clear discards in-flight reads.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_rvalid0  <= 1'b0;
      r_rvalid1  <= 1'b0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
      r_read_sel <= '0;
    end else begin
      r_rvalid0 <= w_rd0;
      r_rvalid1 <= w_rd1;
      if (w_rd0) begin
        r_rdata0 <= rf_dataOut;
      end
      if (w_rd1) begin
        r_rdata1 <= rf_dataOut;
      end
      if (w_rd_acc) begin
        r_read_sel <= w_sel;
      end
    end
  end

  // A read accepted just before clear never reports valid.
  assign req0_rvalid = r_rvalid0 & ~clear;
  assign req1_rvalid = r_rvalid1 & ~clear;
  assign req0_rdata  = r_rdata0;
  assign req1_rdata  = r_rdata1;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter with an external register-file model.
module tb_regfile_arbiter;
  import regfile_pkg::*;

  localparam int LockTmo = 15;

  logic       clk = 1'b0;
  logic       clear;
  logic       req0_valid, req0_write, req0_lock;
  logic [2:0] req0_sel;
  logic [7:0] req0_wdata;
  logic       req0_ready, req0_rvalid;
  logic [7:0] req0_rdata;
  logic       req1_valid, req1_write, req1_lock;
  logic [2:0] req1_sel;
  logic [7:0] req1_wdata;
  logic       req1_ready, req1_rvalid;
  logic [7:0] req1_rdata;
  logic [7:0] rf_dataIn;
  logic [2:0] rf_writeSelect;
  logic       rf_writeEnable;
  logic [2:0] rf_readSelect;
  logic [7:0] rf_dataOut;
  logic       lock_timeout;

  int checks   = 0;
  int failures = 0;

  regfile_arbiter #(
    .DATA_W  (8),
    .SEL_W   (3),
    .LOCK_TMO(LockTmo)
  ) dut (
    .clk           (clk),
    .clear         (clear),
    .req0_valid    (req0_valid),
    .req0_write    (req0_write),
    .req0_sel      (req0_sel),
    .req0_wdata    (req0_wdata),
    .req0_lock     (req0_lock),
    .req0_ready    (req0_ready),
    .req0_rvalid   (req0_rvalid),
    .req0_rdata    (req0_rdata),
    .req1_valid    (req1_valid),
    .req1_write    (req1_write),
    .req1_sel      (req1_sel),
    .req1_wdata    (req1_wdata),
    .req1_lock     (req1_lock),
    .req1_ready    (req1_ready),
    .req1_rvalid   (req1_rvalid),
    .req1_rdata    (req1_rdata),
    .rf_dataIn     (rf_dataIn),
    .rf_writeSelect(rf_writeSelect),
    .rf_writeEnable(rf_writeEnable),
    .rf_readSelect (rf_readSelect),
    .rf_dataOut    (rf_dataOut),
    .lock_timeout  (lock_timeout)
  );

  always #5 clk = ~clk;

  // External register file: written at the edge, read combinationally.
  logic [7:0] rf [8];
  always @(posedge clk) begin
    if (rf_writeEnable) rf[rf_writeSelect] <= rf_dataIn;
  end
  assign rf_dataOut = rf[rf_readSelect];

  // Reference model state: owner (-1 none), last grant, idle count, timeout flag.
  int         m_mode, m_last, m_cnt, m_tmo, m_tmo_owner;
  logic [7:0] m_regs [8];
  logic       m_rv [2];
  logic [7:0] m_rd [2];
  logic [2:0] m_rsel;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = -1; m_last = 1; m_cnt = 0; m_tmo = 0;
    m_rv[0] = 1'b0; m_rv[1] = 1'b0; m_rd[0] = 8'h00; m_rd[1] = 8'h00; m_rsel = 3'd0;
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic step(input bit tab, input logic er0, input logic er1);
    int g;
    int tmo_next;
    logic v [2];
    logic w [2];
    logic l [2];
    logic [2:0] s [2];
    logic [7:0] d [2];
    logic exp_we;
    logic [2:0] exp_rsel;
    @(negedge clk);
    v[0] = req0_valid; w[0] = req0_write; l[0] = req0_lock; s[0] = req0_sel; d[0] = req0_wdata;
    v[1] = req1_valid; w[1] = req1_write; l[1] = req1_lock; s[1] = req1_sel; d[1] = req1_wdata;
    g = -1;
    if (!clear) begin
      if (m_mode < 0) begin
        if (v[0] && v[1]) g = (m_tmo != 0) ? 1 - m_tmo_owner : 1 - m_last;
        else if (v[0]) g = 0;
        else if (v[1]) g = 1;
      end else if (v[m_mode]) begin
        g = m_mode;
      end
    end
    exp_we   = (g >= 0) && w[g];
    exp_rsel = ((g >= 0) && !w[g]) ? s[g] : m_rsel;
    chk("ready0", {31'd0, req0_ready}, {31'd0, g == 0});
    chk("ready1", {31'd0, req1_ready}, {31'd0, g == 1});
    chk("write_en", {31'd0, rf_writeEnable}, {31'd0, exp_we});
    if (exp_we) begin
      chk("write_sel", {29'd0, rf_writeSelect}, {29'd0, s[g]});
      chk("write_data", {24'd0, rf_dataIn}, {24'd0, d[g]});
    end
    chk("read_sel", {29'd0, rf_readSelect}, {29'd0, exp_rsel});
    chk("rvalid0", {31'd0, req0_rvalid}, {31'd0, m_rv[0] && !clear});
    chk("rvalid1", {31'd0, req1_rvalid}, {31'd0, m_rv[1] && !clear});
    chk("rdata0", {24'd0, req0_rdata}, {24'd0, m_rd[0]});
    chk("rdata1", {24'd0, req1_rdata}, {24'd0, m_rd[1]});
    chk("lock_timeout", {31'd0, lock_timeout}, m_tmo);
    if (tab) begin
      chk("tab_ready0", {31'd0, req0_ready}, {31'd0, er0});
      chk("tab_ready1", {31'd0, req1_ready}, {31'd0, er1});
    end
    @(posedge clk);
    if (clear) begin
      model_reset();
    end else begin
      tmo_next = 0;
      m_rv[0] = 1'b0; m_rv[1] = 1'b0;
      if (g >= 0) begin
        if (w[g]) begin
          m_regs[s[g]] = d[g];
        end else begin
          m_rv[g] = 1'b1;
          m_rd[g] = m_regs[s[g]];
          m_rsel  = s[g];
        end
        m_last = g;
        m_mode = l[g] ? g : -1;
        m_cnt  = 0;
      end else if (m_mode >= 0) begin
        m_cnt++;
        if (m_cnt == LockTmo) begin
          m_tmo_owner = m_mode;
          m_mode = -1;
          m_cnt = 0;
          tmo_next = 1;
        end
      end
      m_tmo = tmo_next;
    end
    #1;
  endtask

  task automatic set0(input logic v, input logic w, input logic [2:0] s, input logic [7:0] d,
                      input logic l);
    req0_valid = v; req0_write = w; req0_sel = s; req0_wdata = d; req0_lock = l;
  endtask

  task automatic set1(input logic v, input logic w, input logic [2:0] s, input logic [7:0] d,
                      input logic l);
    req1_valid = v; req1_write = w; req1_sel = s; req1_wdata = d; req1_lock = l;
  endtask

  task automatic do_reset();
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    clear = 1'b1;
    step(0, 0, 0);
    step(0, 0, 0);
    clear = 1'b0;
  endtask

  typedef struct {
    logic v0, w0, l0; logic [2:0] s0; logic [7:0] d0;
    logic v1, w1, l1; logic [2:0] s1; logic [7:0] d1;
    logic r0, r1;
  } vec_t;

  vec_t tab [10];

  function automatic vec_t mk(input logic v0, input logic w0, input logic l0,
                              input logic [2:0] s0, input logic [7:0] d0,
                              input logic v1, input logic w1, input logic l1,
                              input logic [2:0] s1, input logic [7:0] d1,
                              input logic r0, input logic r1);
    vec_t t;
    t.v0 = v0; t.w0 = w0; t.l0 = l0; t.s0 = s0; t.d0 = d0;
    t.v1 = v1; t.w1 = w1; t.l1 = l1; t.s1 = s1; t.d1 = d1;
    t.r0 = r0; t.r1 = r1;
    return t;
  endfunction

  initial begin
    // Contention after reset alternates 0,1,0,1; then req1 locks and releases.
    tab[0] = mk(1, 0, 0, R0, 8'h00, 1, 0, 0, R1, 8'h00, 1, 0);
    tab[1] = mk(1, 0, 0, R2, 8'h00, 1, 0, 0, R3, 8'h00, 0, 1);
    tab[2] = mk(1, 1, 0, R4, 8'h44, 1, 1, 0, MD, 8'h66, 1, 0);
    tab[3] = mk(1, 0, 0, R4, 8'h00, 1, 1, 0, MD, 8'h66, 0, 1);
    tab[4] = mk(1, 0, 0, MD, 8'h00, 1, 0, 0, R4, 8'h00, 1, 0);
    tab[5] = mk(1, 0, 0, MD, 8'h00, 1, 1, 1, R1, 8'h11, 0, 1);
    tab[6] = mk(1, 0, 0, MD, 8'h00, 0, 0, 0, R0, 8'h00, 0, 0);
    tab[7] = mk(1, 0, 0, MD, 8'h00, 0, 0, 0, R0, 8'h00, 0, 0);
    tab[8] = mk(1, 0, 0, MD, 8'h00, 1, 1, 0, MA, 8'h77, 0, 1);
    tab[9] = mk(1, 0, 0, R1, 8'h00, 1, 0, 0, MA, 8'h00, 1, 0);

    for (int i = 0; i < 8; i++) begin
      rf[i] = 8'h00;
      m_regs[i] = 8'h00;
    end
    model_reset();
    m_tmo_owner = 0;
    do_reset();

    // Reset state visible once clear drops.
    #2;
    chk("rst_rvalid0", {31'd0, req0_rvalid}, 0);
    chk("rst_rdata0", {24'd0, req0_rdata}, 0);
    chk("rst_read_sel", {29'd0, rf_readSelect}, 0);
    chk("rst_lock_timeout", {31'd0, lock_timeout}, 0);

    for (int i = 0; i < 10; i++) begin
      set0(tab[i].v0, tab[i].w0, tab[i].s0, tab[i].d0, tab[i].l0);
      set1(tab[i].v1, tab[i].w1, tab[i].s1, tab[i].d1, tab[i].l1);
      step(1, tab[i].r0, tab[i].r1);
    end

    // Single write of 0xA5 to R3, then read it back.
    do_reset();
    set0(1, 1, R3, 8'hA5, 0); set1(0, 0, 0, 0, 0);
    #2;
    chk("sw_we", {31'd0, rf_writeEnable}, 1);
    chk("sw_wsel", {29'd0, rf_writeSelect}, 3);
    step(0, 0, 0);
    set0(0, 0, 0, 0, 0);
    step(0, 0, 0);
    set0(1, 0, R3, 8'h00, 0);
    step(0, 0, 0);
    set0(0, 0, 0, 0, 0);
    #2;
    chk("sw_rvalid", {31'd0, req0_rvalid}, 1);
    chk("sw_rdata", {24'd0, req0_rdata}, 32'hA5);
    step(0, 0, 0);
    chk("sw_rvalid_once", {31'd0, req0_rvalid}, 0);

    // Back-to-back write then read of SP.
    set0(1, 1, SP, 8'h3C, 0);
    step(0, 0, 0);
    set0(1, 0, SP, 8'h00, 0);
    step(0, 0, 0);
    set0(0, 0, 0, 0, 0);
    #2;
    chk("b2b_rvalid", {31'd0, req0_rvalid}, 1);
    chk("b2b_rdata", {24'd0, req0_rdata}, 32'h3C);
    step(0, 0, 0);

    // Lock by req0, then 15 idle owner cycles force release to waiting req1.
    set0(1, 1, R2, 8'h22, 1); set1(0, 0, 0, 0, 0);
    step(0, 0, 0);
    set0(0, 0, 0, 0, 0); set1(1, 0, R2, 8'h00, 0);
    for (int i = 0; i < LockTmo; i++) begin
      #2;
      chk("tmo_wait_ready1", {31'd0, req1_ready}, 0);
      chk("tmo_wait_pulse", {31'd0, lock_timeout}, 0);
      step(0, 0, 0);
    end
    set0(1, 0, R2, 8'h00, 0);
    #2;
    chk("tmo_pulse", {31'd0, lock_timeout}, 1);
    chk("tmo_ready1", {31'd0, req1_ready}, 1);
    chk("tmo_ready0", {31'd0, req0_ready}, 0);
    step(0, 0, 0);
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    #2;
    chk("tmo_pulse_once", {31'd0, lock_timeout}, 0);
    step(0, 0, 0);

    // Read accepted, then clear on the next edge: nothing comes back.
    set1(1, 0, R3, 8'h00, 0);
    step(0, 0, 0);
    set1(0, 0, 0, 0, 0);
    clear = 1'b1;
    #2;
    chk("rmr_rvalid_in_clear", {31'd0, req1_rvalid}, 0);
    chk("rmr_we_in_clear", {31'd0, rf_writeEnable}, 0);
    step(0, 0, 0);
    clear = 1'b0;
    #2;
    chk("rmr_rvalid", {31'd0, req1_rvalid}, 0);
    chk("rmr_rdata", {24'd0, req1_rdata}, 0);
    step(0, 0, 0);

    // Randomized traffic against the model; later phases starve owners to hit timeouts.
    for (int i = 0; i < 600; i++) begin
      int pv;
      pv = (i < 300) ? 60 : 15;
      set0($urandom_range(0, 99) < pv, $urandom_range(0, 1), 3'($urandom_range(0, 7)),
           8'($urandom), $urandom_range(0, 2) == 0);
      set1($urandom_range(0, 99) < pv, $urandom_range(0, 1), 3'($urandom_range(0, 7)),
           8'($urandom), $urandom_range(0, 2) == 0);
      clear = ($urandom_range(0, 149) == 0);
      step(0, 0, 0);
    end
    clear = 1'b0;
    set0(0, 0, 0, 0, 0); set1(0, 0, 0, 0, 0);
    step(0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
